// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The fetch FSM encoding is fixed here so that waveforms and other blocks decode it the same way.
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam int          INST_BYTES   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_npc_sel.sv
// Next-PC select: redirect target when redirect is high, otherwise pc + INST_BYTES (wraps modulo 2^XLEN).
// Purely combinational with no backpressure; the caller decides whether dnpc is written.
module ifu_npc_sel
    import ifu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] dnpc
);

    always_comb begin
        dnpc = redirect ? redirect_pc : pc + XLEN'(INST_BYTES);
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer owning the PC, with one outstanding fetch; inst_valid rises 1 cycle after rsp_valid.
// req held until req_ready, inst held until inst_ready; IFU_FETCH_CTRL_MISALIGN_TRAP_EN adds misaligned-redirect traps.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] dnpc,
    output logic            pc_wen
`ifdef IFU_FETCH_CTRL_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap,
    output logic [XLEN-1:0] misalign_pc
`endif
);

    ifu_state_e      state_q, state_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            seq_adv;
    logic            redir_wr;

    ifu_npc_sel #(.XLEN(XLEN)) u_npc_sel (
        .pc          (pc_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dnpc        (dnpc)
    );

`ifdef IFU_FETCH_CTRL_MISALIGN_TRAP_EN
    logic            trap_fire;
    logic            misalign_trap_q, misalign_trap_d;
    logic [XLEN-1:0] misalign_pc_q, misalign_pc_d;

    // A misaligned target still flushes the fetch but leaves pc alone so it is refetched.
    assign trap_fire = redirect && (redirect_pc[1:0] != 2'b00);
    assign redir_wr  = redirect && !trap_fire;

    always_comb begin
        misalign_trap_d = trap_fire;
        misalign_pc_d   = trap_fire ? redirect_pc : misalign_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_trap_q <= 1'b0;
            misalign_pc_q   <= '0;
        end else begin
            misalign_trap_q <= misalign_trap_d;
            misalign_pc_q   <= misalign_pc_d;
        end
    end

    assign misalign_trap = misalign_trap_q;
    assign misalign_pc   = misalign_pc_q;
`else
    assign redir_wr = redirect;
`endif

    always_comb begin
        state_d      = state_q;
        flush_d      = flush_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        seq_adv      = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // An accepted request leaves a response in flight even under redirect.
                if (req_ready) begin
                    state_d = WAIT;
                    if (redirect) flush_d = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    if (rsp_valid) begin
                        flush_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        flush_d = 1'b1;
                    end
                end else if (rsp_valid) begin
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d       = rsp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    seq_adv      = 1'b1;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        pc_wen = !rst && (redir_wr || seq_adv);
        pc_d   = pc_wen ? dnpc : pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            flush_q      <= 1'b0;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign req_valid  = (state_q == REQ);
    assign req_addr   = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: linear handshake sequences with hand-computed expectations.
// Optional trap ports are exercised when IFU_FETCH_CTRL_MISALIGN_TRAP_EN is defined.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic        pc_wen;
`ifdef IFU_FETCH_CTRL_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] misalign_pc;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .dnpc        (dnpc),
        .pc_wen      (pc_wen)
`ifdef IFU_FETCH_CTRL_MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap),
        .misalign_pc   (misalign_pc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_ready = 0; rsp_valid = 0; rsp_data = '0;
        inst_ready = 0; redirect = 1'b1; redirect_pc = 32'h1234_5678;
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_pc_wen", pc_wen, 0);
        redirect = 0;
        step(); step();
        rst = 0;

        // IDLE for one cycle, then REQ
        chk("idle_req_valid", req_valid, 0);
        step();
        chk("req1_valid", req_valid, 1);
        chk("req1_addr", req_addr, 32'h8000_0000);
        req_ready = 1;
        step();
        req_ready = 0;
        chk("wait1_no_req", req_valid, 0);
        rsp_valid = 1; rsp_data = 32'h0000_0013;
        step();
        rsp_valid = 0; rsp_data = '0;
        chk("hold1_inst_valid", inst_valid, 1);
        chk("hold1_inst", inst, 32'h0000_0013);
        chk("hold1_inst_pc", inst_pc, 32'h8000_0000);

        // Decode stalls for five cycles
        for (int i = 0; i < 5; i++) begin
            chk("stall_inst_valid", inst_valid, 1);
            chk("stall_inst", inst, 32'h0000_0013);
            chk("stall_pc_wen", pc_wen, 0);
            chk("stall_no_req", req_valid, 0);
            step();
        end
        inst_ready = 1;
        #1;
        chk("hs_pc_wen", pc_wen, 1);
        chk("hs_dnpc", dnpc, 32'h8000_0004);
        step();
        inst_ready = 0;
        chk("adv_inst_valid", inst_valid, 0);
        chk("adv_req_addr", req_addr, 32'h8000_0004);
        chk("adv_req_valid", req_valid, 1);

        // Redirect while waiting drops the in-flight response
        req_ready = 1;
        step();
        req_ready = 0;
        redirect = 1; redirect_pc = 32'h8000_0100;
        #1;
        chk("wait_redir_pc_wen", pc_wen, 1);
        chk("wait_redir_dnpc", dnpc, 32'h8000_0100);
        step();
        redirect = 0;
        chk("wait_redir_pc", pc, 32'h8000_0100);
        chk("wait_redir_still_wait", req_valid, 0);
        rsp_valid = 1; rsp_data = 32'hDEAD_BEEF;
        step();
        rsp_valid = 0;
        chk("flush_inst_valid", inst_valid, 0);
        chk("flush_req_valid", req_valid, 1);
        chk("flush_req_addr", req_addr, 32'h8000_0100);

        // Redirect in HOLD squashes a simultaneous decode handshake
        req_ready = 1;
        step();
        req_ready = 0;
        rsp_valid = 1; rsp_data = 32'h0000_0093;
        step();
        rsp_valid = 0;
        chk("hold2_inst", inst, 32'h0000_0093);
        chk("hold2_inst_pc", inst_pc, 32'h8000_0100);
        redirect = 1; redirect_pc = 32'h8000_0040; inst_ready = 1;
        #1;
        chk("hold_redir_dnpc", dnpc, 32'h8000_0040);
        step();
        redirect = 0; inst_ready = 0;
        chk("hold_redir_inst_valid", inst_valid, 0);
        chk("hold_redir_pc", pc, 32'h8000_0040);
        chk("hold_redir_req_addr", req_addr, 32'h8000_0040);

        // Redirect in REQ without acceptance, then PC wrap
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 0;
        chk("req_redir_stay", req_valid, 1);
        chk("req_redir_addr", req_addr, 32'hFFFF_FFFC);
        req_ready = 1;
        step();
        req_ready = 0;
        rsp_valid = 1; rsp_data = 32'h0000_0033;
        step();
        rsp_valid = 0;
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1;
        #1;
        chk("wrap_dnpc", dnpc, 32'h0000_0000);
        step();
        inst_ready = 0;
        chk("wrap_pc", pc, 32'h0000_0000);

        // Redirect coincident with rsp_valid in WAIT: dropped, flush not left set
        req_ready = 1;
        step();
        req_ready = 0;
        redirect = 1; redirect_pc = 32'h8000_0200; rsp_valid = 1; rsp_data = 32'h1111_1111;
        step();
        redirect = 0; rsp_valid = 0;
        chk("coinc_inst_valid", inst_valid, 0);
        chk("coinc_req_valid", req_valid, 1);
        chk("coinc_pc", pc, 32'h8000_0200);
        req_ready = 1;
        step();
        req_ready = 0;
        rsp_valid = 1; rsp_data = 32'h0000_00B3;
        step();
        rsp_valid = 0;
        chk("coinc_next_inst_valid", inst_valid, 1);
        chk("coinc_next_inst", inst, 32'h0000_00B3);

        // Reset asserted mid-WAIT
        inst_ready = 1;
        step();
        inst_ready = 0;
        req_ready = 1;
        step();
        req_ready = 0;
        rst = 1;
        #1;
        chk("mid_rst_req_valid", req_valid, 0);
        chk("mid_rst_inst_valid", inst_valid, 0);
        chk("mid_rst_inst", inst, 0);
        chk("mid_rst_pc", pc, 32'h8000_0000);
        chk("mid_rst_pc_wen", pc_wen, 0);
        step();
        rst = 0;
        rsp_valid = 1; rsp_data = 32'hBAD0_BAD0;
        step();
        chk("stray_rsp_inst_valid", inst_valid, 0);
        chk("stray_rsp_req_valid", req_valid, 1);
        rsp_valid = 0;

        // Misaligned redirect in REQ
        redirect = 1; redirect_pc = 32'h8000_0002;
        #1;
`ifdef IFU_FETCH_CTRL_MISALIGN_TRAP_EN
        chk("mis_pc_wen", pc_wen, 0);
        step();
        redirect = 0;
        chk("mis_trap", misalign_trap, 1);
        chk("mis_trap_pc", misalign_pc, 32'h8000_0002);
        chk("mis_pc_kept", pc, 32'h8000_0000);
        chk("mis_refetch", req_addr, 32'h8000_0000);
        step();
        chk("mis_trap_pulse", misalign_trap, 0);
`else
        chk("mis_pc_wen", pc_wen, 1);
        step();
        redirect = 0;
        chk("mis_pc_taken", pc, 32'h8000_0002);
        chk("mis_req_addr", req_addr, 32'h8000_0002);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter. It issues fetch requests to instruction memory over a valid/ready request/response pair and presents fetched instructions to decode.
- It advances the PC by 4 or redirects it on a jump, branch or trap target from execute.
- Sits between the PC datapath (adder plus register) and the IFU memory port. It generates the PC write-enable so the PC updates only after a completed instruction handoff or a redirect.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- XLEN, 32, address/instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  XLEN  fetch address (= pc).
- rsp_valid  in  1  memory returns instruction.
- rsp_data  in  XLEN  instruction word.
- inst_valid  out  1  instruction valid to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  XLEN  registered instruction.
- inst_pc  out  XLEN  PC of inst.
- redirect  in  1  one-cycle redirect pulse from execute.
- redirect_pc  in  XLEN  redirect target.
- pc  out  XLEN  current PC.
- dnpc  out  XLEN  next PC (redirect_pc if redirect, else pc+4), combinational.
- pc_wen  out  1  PC register write enable this cycle.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=IDLE, req_valid=0, inst_valid=0, inst=0, inst_pc=0, flush=0. pc_wen=0 while in reset.
- States are IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after reset release, then go to REQ.
- REQ: req_valid=1, req_addr=pc, held stable until req_ready. On req_valid&&req_ready go to WAIT.
- WAIT: on rsp_valid, latch inst=rsp_data and inst_pc=pc, set inst_valid=1, go to HOLD. If flush is set, discard the response instead, clear flush, go to REQ.
- HOLD: inst_valid=1 until inst_ready. On the handshake: pc_wen=1, pc<=pc+4, inst_valid<=0, go to REQ.
- Minimum latency is request-accept to inst_valid = 1 cycle after rsp_valid. Best-case throughput is one instruction per 3 cycles.
- Redirect has priority over sequential advance in every state:
  - Effect: pc_wen=1, pc<=redirect_pc, dnpc=redirect_pc.
  - REQ: if req_ready is also high that cycle, the request has been issued, so set flush and go to WAIT. Otherwise stay in REQ; req_addr changes only in the next cycle.
  - WAIT: set flush, stay in WAIT; the pending response is dropped.
  - HOLD: inst_valid<=0 (any simultaneous inst_ready handshake is squashed), go to REQ.
  - IDLE: just update pc.
- A redirect during WAIT in the same cycle as rsp_valid drops the response, goes to REQ, and clears flush.
- Back-to-back redirects: the last one wins; flush stays set.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- No new request is issued while a response is outstanding. At most one outstanding fetch.
- Asserting rst mid-transaction forces IDLE. Any later stray rsp_valid is ignored outside WAIT.

Optional Feature:
- Macro: IFU_FETCH_CTRL_MISALIGN_TRAP_EN.
- When defined, extra outputs are added:
  - misalign_trap (1 bit, registered, reset 0).
  - misalign_pc (XLEN, reset 0).
- With the macro, a redirect with redirect_pc[1:0]!=0 does not write pc. Instead it pulses misalign_trap for one cycle with misalign_pc=redirect_pc, flushes as above, and refetches the unchanged pc.
- Without the macro, the low two bits are taken as given and no trap ports exist.

Decomposition:
- Package ifu_pkg holds:
  - state enum (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3);
  - RESET_PC default;
  - INST_BYTES=4.
- One natural sub-module, ifu_npc_sel: combinational pc+4 / redirect mux producing dnpc.
- State, flush, pc and output registers live in ifu_fetch_ctrl.

Test Plan:
- Reset then req_ready=1, rsp_valid 1 cycle later with data 32'h0000_0013, inst_ready=1 -> req_addr=32'h8000_0000, inst=32'h13, inst_pc=32'h8000_0000, next req_addr=32'h8000_0004.
- inst_ready held 0 for 5 cycles -> inst_valid stays 1, inst stable, pc_wen=0, no new req_valid.
- redirect to 32'h8000_0100 in WAIT, then rsp_valid with 32'hDEAD_BEEF -> response dropped, inst_valid stays 0, next req_addr=32'h8000_0100.
- redirect to 32'h8000_0040 in HOLD with inst_ready=1 -> no handshake counted, pc=32'h8000_0040, next req_addr=32'h8000_0040.
- pc=32'hFFFF_FFFC, one completed fetch -> pc=32'h0000_0000.
- rst asserted mid-WAIT -> all outputs at reset values immediately. With IFU_FETCH_CTRL_MISALIGN_TRAP_EN: redirect_pc=32'h8000_0002 -> misalign_trap 1 cycle, pc unchanged.
